biu_test_master_mc: RTL and testbench

- Multi-channel bus test master. Splits a wide switch input into NUM_CHANNELS groups of SW_WIDTH bits.
- Debounces each group, then writes each settled value to its own slave address through a biu_master.
- Optionally reads the value back and compares it. Mismatches and completed writes are counted.
- Sits between board switches and bus_if. It is the drop-in test master for bring-up of seg7_controller and other slaves.

---
 rtl/biu_test_master_mc_pkg.sv | 36 +++
 rtl/biu_test_master_mc_if.sv | 16 +
 rtl/biu_test_master_mc_debounce.sv | 43 ++++
 rtl/biu_test_master_mc.sv | 158 +++++++++++++++
 tb/tb_biu_test_master_mc.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/biu_test_master_mc_pkg.sv
// Shared types and helpers for the multi-channel bus test master:
// FSM state encoding, data replication and per-channel address generation.
package biu_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_WR,
    WAIT_WR,
    ISSUE_RD,
    WAIT_RD,
    CHECK
  } state_t;

  localparam int MAX_WIDTH = 64;

  // Callers size-cast the result down to their own bus width.
  function automatic logic [MAX_WIDTH-1:0] replicate(input logic [MAX_WIDTH-1:0] value,
                                                     input int sw_width,
                                                     input int copies);
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] result;
    mask   = (MAX_WIDTH'(1) << sw_width) - MAX_WIDTH'(1);
    result = '0;
    for (int i = 0; i < copies; i++) begin
      result = result | ((value & mask) << (i * sw_width));
    end
    return result;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] chan_addr(input logic [MAX_WIDTH-1:0] base,
                                                     input logic [MAX_WIDTH-1:0] stride,
                                                     input int chan);
    return base + stride * MAX_WIDTH'(chan);
  endfunction

endpackage

// File: rtl/biu_test_master_mc_if.sv
// Handshake between the test master and the bus interface unit: a one-cycle
// en pulse starts a transfer, busy stays high until it has finished.
interface bus_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  en;
  logic                  rnw;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] data_in;

  modport master (output en, rnw, addr, data_out, input data_in, busy);
  modport slave  (input en, rnw, addr, data_out, output data_in, busy);
endinterface

// File: rtl/biu_test_master_mc_debounce.sv
// Per-channel debouncer: raises pending once a synchronized switch group has
// held a new value long enough, and drops it when the channel is granted.
module biu_test_debounce #(
  parameter int SW_WIDTH      = 16,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [SW_WIDTH-1:0] syncd,
  input  logic [SW_WIDTH-1:0] committed,
  input  logic                grant,
  output logic                pending
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [SW_WIDTH-1:0] prev;
  logic [CNT_W-1:0]    cnt;
  logic                settled;

  // A change in the current cycle vetoes a stale saturated count.
  assign settled = (cnt == CNT_W'(STABLE_CYCLES)) && (syncd == prev);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      prev    <= '0;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      prev <= syncd;
      if (syncd != prev) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(STABLE_CYCLES)) begin
        cnt <= cnt + 1'b1;
      end
      // Grant wins: committed only catches up with syncd on the next cycle.
      if (grant) begin
        pending <= 1'b0;
      end else if (settled && (syncd != committed)) begin
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/biu_test_master_mc.sv
// Multi-channel bus test master: debounces switch groups, writes each settled
// value to its own slave address and optionally reads it back to compare.
module biu_test_master_mc
  import biu_test_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    NUM_CHANNELS  = 2,
  parameter int                    SW_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = ADDR_WIDTH'(32'hc000_0000),
  parameter logic [ADDR_WIDTH-1:0] ADDR_STRIDE   = ADDR_WIDTH'(32'h4),
  parameter int                    STABLE_CYCLES = 3,
  parameter int                    VERIFY        = 1,
  localparam int                   CHAN_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [NUM_CHANNELS*SW_WIDTH-1:0] sw_input,
  bus_if.master                            bus,
  output logic                             o_busy,
  output logic [CHAN_W-1:0]                o_last_chan,
  output logic [15:0]                      o_wr_count,
  output logic [15:0]                      o_err_count
);
  localparam int REPS = DATA_WIDTH / SW_WIDTH;

  logic [NUM_CHANNELS*SW_WIDTH-1:0] sync_meta, sync_out;
  logic [SW_WIDTH-1:0]   syncd     [NUM_CHANNELS];
  logic [SW_WIDTH-1:0]   committed [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] pending, grant;

  state_t              state, state_next;
  logic [CHAN_W-1:0]   chan, last_grant, rr_chan, last_chan;
  logic                rr_found;
  logic [SW_WIDTH-1:0] value;
  logic [DATA_WIDTH-1:0] expected, rdata_cap;
  logic [15:0]         wr_count, err_count;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= sw_input;
      sync_out  <= sync_meta;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    assign syncd[c] = sync_out[c*SW_WIDTH +: SW_WIDTH];

    biu_test_debounce #(
      .SW_WIDTH      (SW_WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .n_rst     (n_rst),
      .syncd     (syncd[c]),
      .committed (committed[c]),
      .grant     (grant[c]),
      .pending   (pending[c])
    );
  end

  // Round-robin search starts one past the most recently granted channel.
  always_comb begin
    rr_found = 1'b0;
    rr_chan  = last_grant;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      if (!rr_found && pending[CHAN_W'((int'(last_grant) + i) % NUM_CHANNELS)]) begin
        rr_found = 1'b1;
        rr_chan  = CHAN_W'((int'(last_grant) + i) % NUM_CHANNELS);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == IDLE && rr_found) begin
      grant[rr_chan] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    bus.en     = 1'b0;
    bus.rnw    = 1'b0;
    case (state)
      IDLE:     if (rr_found) state_next = ISSUE_WR;
      ISSUE_WR: if (!bus.busy) begin
                  bus.en     = 1'b1;
                  state_next = WAIT_WR;
                end
      WAIT_WR:  if (!bus.busy) state_next = (VERIFY != 0) ? ISSUE_RD : IDLE;
      ISSUE_RD: begin
                  bus.rnw = 1'b1;
                  if (!bus.busy) begin
                    bus.en     = 1'b1;
                    state_next = WAIT_RD;
                  end
                end
      WAIT_RD:  begin
                  bus.rnw = 1'b1;
                  if (!bus.busy) state_next = CHECK;
                end
      CHECK:    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign expected     = DATA_WIDTH'(replicate(MAX_WIDTH'(value), SW_WIDTH, REPS));
  assign bus.data_out = expected;
  assign bus.addr     = ADDR_WIDTH'(chan_addr(MAX_WIDTH'(BASE_ADDR), MAX_WIDTH'(ADDR_STRIDE), int'(chan)));

  // Pointer resets to the last channel so channel 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int c = 0; c < NUM_CHANNELS; c++) committed[c] <= '0;
      chan       <= '0;
      value      <= '0;
      last_grant <= CHAN_W'(NUM_CHANNELS - 1);
      last_chan  <= '0;
      wr_count   <= '0;
      err_count  <= '0;
      rdata_cap  <= '0;
    end else begin
      if (state == IDLE && rr_found) begin
        chan               <= rr_chan;
        value              <= syncd[rr_chan];
        committed[rr_chan] <= syncd[rr_chan];
        last_grant         <= rr_chan;
      end
      if (state == WAIT_WR && !bus.busy) begin
        wr_count  <= wr_count + 16'd1;
        last_chan <= chan;
      end
      if (state == WAIT_RD && !bus.busy) begin
        rdata_cap <= bus.data_in;
      end
      if (state == CHECK && rdata_cap != expected && err_count != 16'hffff) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

  assign o_busy      = (state != IDLE);
  assign o_last_chan = last_chan;
  assign o_wr_count  = wr_count;
  assign o_err_count = err_count;
endmodule

// File: tb/tb_biu_test_master_mc.sv
// Scoreboard bench for biu_test_master_mc: a small BIU/slave model answers the
// handshake, expected transfers are queued as switches are driven.
module tb_biu_test_master_mc;
  import biu_test_pkg::*;

  localparam int NCH = 2;
  localparam int SW  = 16;

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [NCH*SW-1:0] sw_input;
  logic            o_busy;
  logic            o_last_chan;
  logic [15:0]     o_wr_count;
  logic [15:0]     o_err_count;

  txn_t        sb[$];
  txn_t        exp_txn;
  int          test_count = 0;
  int          fail_count = 0;
  int          exp_wr     = 0;
  int          exp_err    = 0;
  logic        corrupt    = 1'b0;
  logic [31:0] mem [4];
  int          lat;

  bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  biu_test_master_mc #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .NUM_CHANNELS  (NCH),
    .SW_WIDTH      (SW),
    .BASE_ADDR     (32'hc000_0000),
    .ADDR_STRIDE   (32'h4),
    .STABLE_CYCLES (3),
    .VERIFY        (1)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .sw_input    (sw_input),
    .bus         (bus),
    .o_busy      (o_busy),
    .o_last_chan (o_last_chan),
    .o_wr_count  (o_wr_count),
    .o_err_count (o_err_count)
  );

  always #5 clk = ~clk;

  // BIU + slave model: busy for three cycles after each accepted pulse.
  always @(posedge clk) begin
    if (!n_rst) begin
      bus.busy    <= 1'b0;
      bus.data_in <= '0;
      lat         <= 0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else if (bus.en && !bus.busy) begin
      bus.busy <= 1'b1;
      lat      <= 3;
      if (bus.rnw) bus.data_in <= mem[bus.addr[3:2]] ^ {31'b0, corrupt};
      else         mem[bus.addr[3:2]] <= bus.data_out;
    end else if (bus.busy) begin
      if (lat == 1) bus.busy <= 1'b0;
      lat <= lat - 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (bus.en === 1'b1) begin
      checkOutput("en_while_busy", {31'b0, bus.busy}, 32'd0);
      checkOutput("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_txn = sb.pop_front();
        checkOutput("txn_rnw", {31'b0, bus.rnw}, {31'b0, exp_txn.rnw});
        checkOutput("txn_addr", bus.addr, exp_txn.addr);
        if (!exp_txn.rnw) checkOutput("txn_wdata", bus.data_out, exp_txn.data);
      end
    end
  end

  task automatic applyStimulus(input int chan, input logic [15:0] value, input bit expect_write);
    logic [31:0] addr;
    sw_input[chan*SW +: SW] = value;
    if (expect_write) begin
      addr = 32'hc000_0000 + 32'(chan) * 32'h4;
      sb.push_back('{1'b0, addr, {value, value}});
      sb.push_back('{1'b1, addr, {value, value}});
      exp_wr++;
      if (corrupt && exp_err != 16'hffff) exp_err++;
    end
  endtask

  task automatic doReset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    sb.delete();
    exp_wr  = 0;
    exp_err = 0;
  endtask

  task automatic waitIdle();
    int cycles = 0;
    repeat (4) @(negedge clk);
    while ((sb.size() != 0 || o_busy) && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("drain_queue", 32'(sb.size()), 32'd0);
    checkOutput("drain_busy", {31'b0, o_busy}, 32'd0);
  endtask

  task automatic waitEn(input logic rnw, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.en === 1'b1 && bus.rnw === rnw) seen = 1'b1;
    end
  endtask

  task automatic checkCounts(input string tag, input logic last);
    checkOutput({tag, "_wr"}, {16'b0, o_wr_count}, 32'(exp_wr & 16'hffff));
    checkOutput({tag, "_err"}, {16'b0, o_err_count}, 32'(exp_err));
    checkOutput({tag, "_last"}, {31'b0, o_last_chan}, {31'b0, last});
  endtask

  initial begin
    int  busy_cycles;
    bit  seen;

    sw_input = '0;
    doReset();
    checkOutput("rst_busy", {31'b0, o_busy}, 32'd0);
    checkCounts("rst", 1'b0);

    applyStimulus(0, 16'h1234, 1'b1);
    waitIdle();
    checkCounts("single", 1'b0);

    busy_cycles = 0;
    applyStimulus(1, 16'h00ff, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(1, 16'h0000, 1'b0);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (o_busy) busy_cycles++;
    end
    checkOutput("glitch_busy", 32'(busy_cycles), 32'd0);
    checkCounts("glitch", 1'b0);

    sw_input = '0;
    doReset();
    applyStimulus(0, 16'haaaa, 1'b1);
    applyStimulus(1, 16'h5555, 1'b1);
    waitIdle();
    checkCounts("both", 1'b1);

    corrupt = 1'b1;
    applyStimulus(0, 16'h0f0f, 1'b1);
    waitIdle();
    checkCounts("corrupt", 1'b0);
    force dut.err_count = 16'hffff;
    @(negedge clk);
    release dut.err_count;
    exp_err = 16'hffff;
    applyStimulus(1, 16'h0101, 1'b1);
    waitIdle();
    checkCounts("saturate", 1'b1);
    corrupt = 1'b0;

    applyStimulus(0, 16'h7777, 1'b1);
    waitEn(1'b0, seen);
    checkOutput("saw_wr_en", {31'b0, seen}, 32'd1);
    applyStimulus(0, 16'h0001, 1'b0);
    @(negedge clk);
    applyStimulus(0, 16'h0002, 1'b1);
    waitIdle();
    checkCounts("reorder", 1'b0);

    applyStimulus(1, 16'h4321, 1'b1);
    waitEn(1'b1, seen);
    checkOutput("saw_rd_en", {31'b0, seen}, 32'd1);
    n_rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", {31'b0, o_busy}, 32'd0);
    checkOutput("midrst_en", {31'b0, bus.en}, 32'd0);
    checkOutput("midrst_queue", 32'(sb.size()), 32'd0);
    exp_wr  = 0;
    exp_err = 0;
    checkCounts("midrst", 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    applyStimulus(0, 16'h0002, 1'b1);
    applyStimulus(1, 16'h4321, 1'b1);
    waitIdle();
    checkCounts("rewrite", 1'b1);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end
endmodule
